// File: rtl/data_bus_pkg.sv
// Shared types and helpers for the data-port responder.
// State encoding, word size and the address range check used by the
// responder in both the wait-state and zero-latency builds.
package data_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } bus_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned MAX_WAIT   = 15;

    // True when addr lies in [base, base + WORD_BYTES*words); widened so the
    // upper bound cannot wrap at the top of the 32-bit space.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned words);
        logic [33:0] a;
        logic [33:0] lo;
        logic [33:0] hi;
        a  = {2'b00, addr};
        lo = {2'b00, base};
        hi = lo + 34'(words) * 34'(WORD_BYTES);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/data_bus_ram.sv
// Word array behind the data-port responder.
// Synchronous write, combinational read; contents are never reset.
module data_bus_ram
    import data_bus_pkg::*;
#(
    parameter int unsigned ADDR_WORDS = 1024,
    parameter int unsigned IDX_W      = 10
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IDX_W-1:0]          waddr,
    input  logic [8*WORD_BYTES-1:0]   wdata,
    input  logic [IDX_W-1:0]          raddr,
    output logic [8*WORD_BYTES-1:0]   rdata
);

    logic [8*WORD_BYTES-1:0] mem [ADDR_WORDS];

    // Commit a word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_bus_responder.sv
// Word-addressed data-memory responder for the Harvard CPU data port.
// Define DATA_BUS_WAIT_EN to compile in the wait-state FSM (WAIT_CYCLES
// stall cycles per access); otherwise reads are combinational and writes
// commit on the enabled posedge with no stall.
module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int unsigned ADDR_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable_in,
    output logic        clk_enable,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        bus_error
);

    localparam int unsigned IDX_W    = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
    localparam int unsigned WAIT_LIM = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
    localparam logic [3:0]  WAIT_N   = 4'(WAIT_LIM);

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             req;
    logic             req_err;
    logic             rd_only;
    logic             stall;
    logic             idle_now;

    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [31:0]      ram_wdata;
    logic [IDX_W-1:0] ram_raddr;
    logic [31:0]      ram_rdata;

    assign idx      = IDX_W'((data_address - BASE_ADDR) >> 2);
    assign in_range = addr_in_range(data_address, BASE_ADDR, ADDR_WORDS);
    assign req      = data_read | data_write;
    assign req_err  = ~in_range | (data_read & data_write);
    assign rd_only  = data_read & ~data_write;

    data_bus_ram #(
        .ADDR_WORDS (ADDR_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

`ifdef DATA_BUS_WAIT_EN
    bus_state_t       state;
    logic [3:0]       count;
    logic [IDX_W-1:0] req_idx;
    logic [31:0]      req_data;
    logic             req_write;
    logic             req_rd_only;
    logic             req_ok;
    logic [31:0]      rd_data;

    assign idle_now  = (state == IDLE);
    assign ram_raddr = idle_now ? idx : req_idx;

    // Stall the core from the request cycle until the access is READY.
    always_comb begin
        stall = 1'b0;
        if (WAIT_N != 4'd0) begin
            stall = (idle_now && req) || (state == WAIT);
        end
    end

    // Write port and read-data source: live request at zero wait, latched request otherwise.
    always_comb begin
        ram_we        = 1'b0;
        ram_waddr     = req_idx;
        ram_wdata     = req_data;
        data_readdata = rd_data;
        if (WAIT_N == 4'd0) begin
            ram_we        = clk_enable_in && idle_now && data_write && in_range;
            ram_waddr     = idx;
            ram_wdata     = data_writedata;
            data_readdata = (rd_only && in_range) ? ram_rdata : '0;
        end else begin
            ram_we = clk_enable_in && (state == READY) && req_write && req_ok;
        end
    end

    // Wait-state FSM. The IDLE cycle already counts as one stall, so WAIT
    // leaves once the incremented count reaches WAIT_N, and WAIT_N == 1 goes
    // straight to READY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            req_idx     <= '0;
            req_data    <= '0;
            req_write   <= 1'b0;
            req_rd_only <= 1'b0;
            req_ok      <= 1'b0;
            rd_data     <= '0;
        end else if (clk_enable_in) begin
            case (state)
                IDLE: begin
                    if (req && (WAIT_N != 4'd0)) begin
                        req_idx     <= idx;
                        req_data    <= data_writedata;
                        req_write   <= data_write;
                        req_rd_only <= rd_only;
                        req_ok      <= in_range;
                        count       <= 4'd1;
                        if (WAIT_N == 4'd1) begin
                            state   <= READY;
                            rd_data <= (rd_only && in_range) ? ram_rdata : '0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    count <= count + 4'd1;
                    if (count + 4'd1 == WAIT_N) begin
                        state   <= READY;
                        rd_data <= (req_rd_only && req_ok) ? ram_rdata : '0;
                    end
                end
                READY: begin
                    state   <= IDLE;
                    count   <= '0;
                    rd_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign idle_now      = 1'b1;
    assign stall         = 1'b0;
    assign ram_raddr     = idx;
    assign ram_we        = clk_enable_in && data_write && in_range;
    assign ram_waddr     = idx;
    assign ram_wdata     = data_writedata;
    assign data_readdata = (rd_only && in_range) ? ram_rdata : '0;
`endif

    assign clk_enable = clk_enable_in & ~stall;

    // Sticky error on an accepted out-of-range or read+write request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_error <= 1'b0;
        end else if (clk_enable_in && idle_now && req && req_err) begin
            bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed self-checking bench for data_bus_responder.
// Expected stall count follows the build: WAIT_CYCLES with
// DATA_BUS_WAIT_EN defined, zero otherwise.
module tb_data_bus_responder;

`ifdef DATA_BUS_WAIT_EN
    localparam int EXP_W = 2;
`else
    localparam int EXP_W = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable_in;
    logic        clk_enable;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        bus_error;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    data_bus_responder #(
        .ADDR_WORDS  (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable_in  (clk_enable_in),
        .clk_enable     (clk_enable),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .bus_error      (bus_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and wait (bounded) for the cycle the CPU advances.
    task automatic bus_access(input logic [31:0] a, input logic rd, input logic wr,
                              input logic [31:0] wd, output logic [31:0] rdata,
                              output int stalls);
        int guard;
        data_address   = a;
        data_read      = rd;
        data_write     = wr;
        data_writedata = wd;
        stalls = 0;
        guard  = 0;
        @(negedge clk);
        while (!clk_enable && guard < 40) begin
            stalls++;
            guard++;
            @(negedge clk);
        end
        rdata = data_readdata;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        data_read  = 1'b0;
        data_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          st;

        reset          = 1'b1;
        clk_enable_in  = 1'b1;
        data_address   = '0;
        data_write     = 1'b0;
        data_read      = 1'b0;
        data_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_clk_enable", 32'(clk_enable), 32'd1);
        check_eq("rst_readdata", data_readdata, 32'h0);
        check_eq("rst_bus_error", 32'(bus_error), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic write/read and unaligned read
        bus_access(32'h100, 1'b0, 1'b1, 32'h0000_5501, rd, st);
        check_eq("wr100_stalls", 32'(st), 32'(EXP_W));
        bus_access(32'h100, 1'b1, 1'b0, '0, rd, st);
        check_eq("rd100_data", rd, 32'h0000_5501);
        check_eq("rd100_stalls", 32'(st), 32'(EXP_W));
        bus_access(32'h103, 1'b1, 1'b0, '0, rd, st);
        check_eq("rd103_data", rd, 32'h0000_5501);
        check_eq("rd103_bus_error", 32'(bus_error), 32'd0);
        bus_idle();
        check_eq("idle_readdata", data_readdata, 32'h0);

        // Out of range: word 0 must not be hit by the truncated index
        bus_access(32'h0, 1'b0, 1'b1, 32'h0000_0A0A, rd, st);
        bus_access(32'h1000, 1'b0, 1'b1, 32'hFFFF_FFFF, rd, st);
        check_eq("oor_wr_bus_error", 32'(bus_error), 32'd1);
        bus_access(32'h1000, 1'b1, 1'b0, '0, rd, st);
        check_eq("oor_rd_data", rd, 32'h0);
        bus_access(32'h0, 1'b1, 1'b0, '0, rd, st);
        check_eq("word0_intact", rd, 32'h0000_0A0A);
        bus_idle();
        bus_idle();
        check_eq("bus_error_sticky", 32'(bus_error), 32'd1);
        pulse_reset();
        check_eq("bus_error_cleared", 32'(bus_error), 32'd0);

        // Read and write together: treated as a write, flagged
        bus_access(32'h20, 1'b1, 1'b1, 32'hDEAD_BEEF, rd, st);
        check_eq("both_bus_error", 32'(bus_error), 32'd1);
        check_eq("both_stalls", 32'(st), 32'(EXP_W));
        bus_idle();
        bus_access(32'h20, 1'b1, 1'b0, '0, rd, st);
        check_eq("both_rd_data", rd, 32'hDEAD_BEEF);
        pulse_reset();

        // Reset in the middle of a write
        bus_access(32'h40, 1'b0, 1'b1, 32'hAAAA_0000, rd, st);
        bus_idle();
`ifdef DATA_BUS_WAIT_EN
        data_address   = 32'h40;
        data_write     = 1'b1;
        data_writedata = 32'h1234_5678;
        @(negedge clk);
        check_eq("mid_req_stall", 32'(clk_enable), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("mid_wait_stall", 32'(clk_enable), 32'd0);
        reset      = 1'b1;
        data_write = 1'b0;
        #1;
        check_eq("mid_rst_clk_enable", 32'(clk_enable), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
`endif
        bus_access(32'h40, 1'b1, 1'b0, '0, rd, st);
        check_eq("rd40_kept", rd, 32'hAAAA_0000);

        // Back-to-back accesses with no idle cycles
        bus_access(32'h8, 1'b0, 1'b1, 32'h1, rd, st);
        check_eq("b2b_wr8_stalls", 32'(st), 32'(EXP_W));
        bus_access(32'hC, 1'b0, 1'b1, 32'h2, rd, st);
        check_eq("b2b_wrC_stalls", 32'(st), 32'(EXP_W));
        bus_access(32'h8, 1'b1, 1'b0, '0, rd, st);
        check_eq("b2b_rd8_data", rd, 32'h1);
        check_eq("b2b_rd8_stalls", 32'(st), 32'(EXP_W));
        bus_access(32'hC, 1'b1, 1'b0, '0, rd, st);
        check_eq("b2b_rdC_data", rd, 32'h2);
        check_eq("b2b_rdC_stalls", 32'(st), 32'(EXP_W));
        bus_idle();

        // External enable low freezes the access
        clk_enable_in = 1'b0;
        data_address  = 32'h8;
        data_read     = 1'b1;
        #1;
        check_eq("freeze_clk_enable", 32'(clk_enable), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("freeze_held", 32'(clk_enable), 32'd0);
        clk_enable_in = 1'b1;
        bus_access(32'h8, 1'b1, 1'b0, '0, rd, st);
        check_eq("freeze_rd_data", rd, 32'h1);
        check_eq("freeze_rd_stalls", 32'(st), 32'(EXP_W));
        bus_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
